// File: rtl/display_arbiter.sv
// Display arbiter: shares the dot-matrix frame and 7-seg data among N_REQ requesters.
// Requester 0 preempts; the rest rotate round-robin after MIN_HOLD cycles of contention.
// Ports: clk, rst (sync, active-high), req[N_REQ], matrix_in[N_REQ*128], numbers_in[N_REQ*32],
//        grant[N_REQ] (one-hot/zero), owner[3], busy, matrix_out[128], numbers_out[32].
// Option: define DISP_BLANK_GAP_EN to insert a BLANK_CYCLES blank gap on every owner change.
module display_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MIN_HOLD     = 10000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*128-1:0] matrix_in,
    input  logic [N_REQ*32-1:0]  numbers_in,
    output logic [N_REQ-1:0]     grant,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic [127:0]         matrix_out,
    output logic [31:0]          numbers_out
);

    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD - 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    if (N_REQ < 2 || N_REQ > 8 || MIN_HOLD < 1 || BLANK_CYCLES < 1) begin : gBadParam
        $error("display_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, HOLD, BLANK} stateT;

    stateT            state, stateNext;
    logic [N_REQ-1:0] grantNext;
    logic [2:0]       ownerNext;
    logic [2:0]       rrPtr;
    logic [HW-1:0]    holdCnt, cntNext;
    logic [3:0]       winAll, winOther;
    logic             ownerReq;
    logic             change;
    logic [2:0]       changeIdx;
    logic [127:0]     selMatrix;
    logic [31:0]      selNumbers;

`ifdef DISP_BLANK_GAP_EN
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYCLES - 1);
    logic [BW-1:0] blankCnt, blankNext;
`endif

    // Cyclic search over ring 1..N_REQ-1 starting at ptr; returns {found, index}.
    // Walking the ring backwards lets the closest hit overwrite farther ones.
    function automatic logic [3:0] pickRr(input logic [N_REQ-1:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        int c;
        res = '0;
        for (int j = N_REQ - 2; j >= 0; j--) begin
            c = (int'(ptr) - 1 + j) % (N_REQ - 1) + 1;
            if (r[c]) res = {1'b1, 3'(c)};
        end
        return res;
    endfunction

    always_comb begin
        winAll   = req[0] ? 4'b1000 : pickRr(req, rrPtr);
        winOther = pickRr(req & ~grant, rrPtr);
        ownerReq = |(req & grant);
    end

    always_comb begin
        selMatrix  = '0;
        selNumbers = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                selMatrix  = selMatrix | matrix_in[i*128 +: 128];
                selNumbers = selNumbers | numbers_in[i*32 +: 32];
            end
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grant;
        ownerNext = owner;
        cntNext   = holdCnt;
        change    = 1'b0;
        changeIdx = '0;
`ifdef DISP_BLANK_GAP_EN
        blankNext = blankCnt;
`endif
        unique case (state)
            IDLE: begin
                if (winAll[3]) begin
                    stateNext = HOLD;
                    grantNext = ONE << winAll[2:0];
                    ownerNext = winAll[2:0];
                    cntNext   = '0;
                end
            end
            HOLD: begin
                if (req[0] && owner != 3'd0) begin
                    change    = 1'b1;
                    changeIdx = 3'd0;
                end else if (!ownerReq) begin
                    if (winAll[3]) begin
                        change    = 1'b1;
                        changeIdx = winAll[2:0];
                    end else begin
                        stateNext = IDLE;
                        grantNext = '0;
                        ownerNext = '0;
                    end
                end else if (owner != 3'd0 && winOther[3] && holdCnt == HOLD_MAX) begin
                    change    = 1'b1;
                    changeIdx = winOther[2:0];
                end else if (holdCnt != HOLD_MAX) begin
                    cntNext = holdCnt + 1'b1;
                end
                if (change) begin
`ifdef DISP_BLANK_GAP_EN
                    stateNext = BLANK;
                    grantNext = '0;
                    ownerNext = '0;
                    blankNext = '0;
`else
                    grantNext = ONE << changeIdx;
                    ownerNext = changeIdx;
                    cntNext   = '0;
`endif
                end
            end
`ifdef DISP_BLANK_GAP_EN
            BLANK: begin
                // The gap decided on a change, but the winner is picked fresh here.
                if (blankCnt == BLANK_MAX) begin
                    if (winAll[3]) begin
                        stateNext = HOLD;
                        grantNext = ONE << winAll[2:0];
                        ownerNext = winAll[2:0];
                        cntNext   = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    blankNext = blankCnt + 1'b1;
                end
            end
`endif
            default: begin
                stateNext = IDLE;
                grantNext = '0;
                ownerNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            holdCnt     <= '0;
            rrPtr       <= 3'd1;
            matrix_out  <= '0;
            numbers_out <= '0;
`ifdef DISP_BLANK_GAP_EN
            blankCnt    <= '0;
`endif
        end else begin
            state   <= stateNext;
            grant   <= grantNext;
            owner   <= ownerNext;
            holdCnt <= cntNext;
`ifdef DISP_BLANK_GAP_EN
            blankCnt <= blankNext;
`endif
            if (stateNext == HOLD && ownerNext != 3'd0)
                rrPtr <= (ownerNext == 3'(N_REQ - 1)) ? 3'd1 : ownerNext + 3'd1;
            // Outputs trail the owner by one cycle and blank as soon as HOLD ends.
            if (state == HOLD && stateNext == HOLD) begin
                matrix_out  <= selMatrix;
                numbers_out <= selNumbers;
            end else begin
                matrix_out  <= '0;
                numbers_out <= '0;
            end
        end
    end

    assign busy = |grant;

endmodule
